// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types and defaults for the nibble-serial add/subtract sequencer.
// The sequencer walks one WIDTH-bit slice per clock through a single shared adder.
package nibble_serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_WORDS = 4;

    // Step counter width: clog2 of the slice count, never narrower than one bit.
    function automatic int unsigned step_bits(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Control-unit <-> sequencer handshake bus: start request with operands, busy/done with results.
// The master side is the control unit; the slave side is the sequencer.
interface nibble_serial_addsub_ctrl_if
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned WORDS = DEF_WORDS
);
    localparam int unsigned N = WIDTH * WORDS;

    logic         start;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         v;
    logic         zero;

    modport master (
        output start, op_a, op_b, sub,
        input  busy, done, result, cout, v, zero
    );

    modport slave (
        input  start, op_a, op_b, sub,
        output busy, done, result, cout, v, zero
    );

endinterface

// File: rtl/addsub_slice.sv
// One WIDTH-bit ripple-carry adder/subtracter slice; s inverts b, carry-in is a separate port.
// v compares the carry into the MSB with the carry out of it.
module addsub_slice #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   c;

    assign bx   = b ^ {WIDTH{s}};
    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout = c[WIDTH];
    assign v    = c[WIDTH] ^ c[WIDTH - 1];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-word add/subtract sequencer: one shared slice adder, LSB slice first,
// carry chained through a register; done pulses one cycle after the last slice.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input logic                          clk,
    input logic                          rst,
    nibble_serial_addsub_ctrl_if.slave   bus
);
    localparam int unsigned N  = WIDTH * WORDS;
    localparam int unsigned SW = step_bits(WORDS);
    localparam logic [SW-1:0] STEP_LAST = SW'(WORDS - 1);

    state_t         state;
    logic [SW-1:0]  step;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic           sub_r;
    logic           carry_r;
    logic [N-1:0]   result_r;
    logic           busy_r;
    logic           done_r;
    logic           cout_r;
    logic           v_r;
    logic           zero_r;

    logic [WIDTH-1:0] a_sl;
    logic [WIDTH-1:0] b_sl;
    logic [WIDTH-1:0] sum_sl;
    logic             cout_sl;
    logic             v_sl;

    assign a_sl = a_r[step * WIDTH +: WIDTH];
    assign b_sl = b_r[step * WIDTH +: WIDTH];

    addsub_slice #(.WIDTH(WIDTH)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .s    (sub_r),
        .cin  (carry_r),
        .sum  (sum_sl),
        .cout (cout_sl),
        .v    (v_sl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            carry_r  <= 1'b0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cout_r   <= 1'b0;
            v_r      <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.op_a;
                        b_r     <= bus.op_b;
                        sub_r   <= bus.sub;
                        carry_r <= bus.sub;
                        step    <= '0;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result_r[step * WIDTH +: WIDTH] <= sum_sl;
                    carry_r <= cout_sl;
                    // Flags come from the MSB slice only; lower slices just feed the carry chain.
                    if (step == STEP_LAST) begin
                        cout_r <= cout_sl;
                        v_r    <= v_sl;
                        state  <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                    zero_r <= (result_r == '0);
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.v      = v_r;
    assign bus.zero   = zero_r;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for the nibble-serial add/subtract sequencer (WIDTH=4, WORDS=4).
// Expected values are hand-computed in the vector table and the sequences below.
module tb_nibble_serial_addsub_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    nibble_serial_addsub_ctrl_if #(.WIDTH(4), .WORDS(4)) bus ();

    nibble_serial_addsub_ctrl #(.WIDTH(4), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        cout;
        logic        v;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t t, input int idx);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = t.a;
        bus.op_b  = t.b;
        bus.sub   = t.sub;
        @(posedge clk);
        #1;
        // Scramble the operand ports after the accept edge; they must not matter.
        bus.start = 1'b0;
        bus.op_a  = ~t.a;
        bus.op_b  = 16'h5A5A;
        bus.sub   = ~t.sub;
        check($sformatf("v%0d busy_after_accept", idx), 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("v%0d latency", idx), 32'(n), 32'd5);
        check($sformatf("v%0d result", idx), 32'(bus.result), 32'(t.res));
        check($sformatf("v%0d cout", idx), 32'(bus.cout), 32'(t.cout));
        check($sformatf("v%0d v", idx), 32'(bus.v), 32'(t.v));
        check($sformatf("v%0d zero", idx), 32'(bus.zero), 32'(t.zero));
        @(posedge clk);
        #1;
        check($sformatf("v%0d done_one_cycle", idx), 32'(bus.done), 32'd0);
        check($sformatf("v%0d busy_after_done", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d result_hold", idx), 32'(bus.result), 32'(t.res));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        tests = 0;
        fails = 0;

        //            a         b         sub   res       cout  v     zero
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.sub   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        check("reset v", 32'(bus.v), 32'd0);
        check("reset zero", 32'(bus.zero), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i], i);

        // start held high: accepts land on edges 0,6,12,18; done follows 5 edges later.
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            bus.start = (c < 20);
            bus.op_a  = 16'(c * 16'h0101);
            bus.op_b  = 16'h0011;
            bus.sub   = 1'b0;
            @(posedge clk);
            #1;
            if (c >= 5 && ((c - 5) % 6) == 0) begin
                check($sformatf("burst done c%0d", c), 32'(bus.done), 32'd1);
                check($sformatf("burst result c%0d", c), 32'(bus.result),
                      32'(16'((c - 5) * 16'h0101 + 16'h0011)));
            end else begin
                check($sformatf("burst done c%0d", c), 32'(bus.done), 32'd0);
            end
        end

        // Reset sampled in the second RUN cycle aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h1111;
        bus.op_b  = 16'h2222;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort result", 32'(bus.result), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort no_done", 32'(done_cnt), 32'd0);
        run_op('{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0}, 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
